// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: read-during-write mode codes and clear/ready state type
package sp_ram_pkg;
  localparam int RDW_NO_CHANGE   = 0;
  localparam int RDW_READ_FIRST  = 1;
  localparam int RDW_WRITE_FIRST = 2;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/sp_ram_array.sv
// sp_ram_array: byte-enable storage with registered read and selectable read-during-write
// ports: clk, rst_n (async, resets rdata only), en/we/be/addr/wdata write-read port,
//        upd (user access may load rdata), zero (load 0 into rdata), rdata
module sp_ram_array
  import sp_ram_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int RDW_MODE  = RDW_NO_CHANGE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   we,
  input  logic                   upd,
  input  logic                   zero,
  input  logic [DATAWIDTH/8-1:0] be,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [DATAWIDTH-1:0]   wdata,
  output logic [DATAWIDTH-1:0]   rdata
);
  logic [DATAWIDTH-1:0] mem [SIZE];
  logic [DATAWIDTH-1:0] merged;
  for (genvar g = 0; g < DATAWIDTH/8; g++) begin : g_merge
    assign merged[8*g +: 8] = be[g] ? wdata[8*g +: 8] : mem[addr][8*g +: 8];
  end
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= merged;
  end
  // clear writes never touch rdata; only user accesses (upd) may load it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (zero) rdata <= '0;
    else if (en && upd && (!we || RDW_MODE != RDW_NO_CHANGE))
      rdata <= (we && RDW_MODE == RDW_WRITE_FIRST) ? merged : mem[addr];
  end
endmodule

// File: rtl/sp_ram_be_clr.sv
// sp_ram_be_clr: single-port byte-enable RAM with zero-clear sequencer and range check
// ports: clk, rst_n (async active-low), cs/we/be/addr/wdata request, clr_start clear request,
//        rdata/rvalid read result, ready accept window, err out-of-range pulse
module sp_ram_be_clr
  import sp_ram_pkg::*;
#(
  parameter int ADDRWIDTH = 4,
  parameter int DATAWIDTH = 8,
  parameter int SIZE      = 16,
  parameter int RDW_MODE  = RDW_NO_CHANGE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs,
  input  logic                   we,
  input  logic [DATAWIDTH/8-1:0] be,
  input  logic [ADDRWIDTH-1:0]   addr,
  input  logic [DATAWIDTH-1:0]   wdata,
  input  logic                   clr_start,
  output logic [DATAWIDTH-1:0]   rdata,
  output logic                   rvalid,
  output logic                   ready,
  output logic                   err
);
  state_t               state;
  logic [ADDRWIDTH-1:0] cnt;
  logic                 clearing, acc, in_range;
  assign clearing = state == CLEAR;
  // a clear request wins over a same-cycle access
  assign acc      = state == READY && cs && !clr_start;
  assign in_range = {1'b0, addr} < (ADDRWIDTH+1)'(SIZE);
  sp_ram_array #(
    .ADDRWIDTH(ADDRWIDTH),
    .DATAWIDTH(DATAWIDTH),
    .SIZE(SIZE),
    .RDW_MODE(RDW_MODE)
  ) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .en(clearing || (acc && in_range)),
    .we(clearing || we),
    .upd(acc && in_range),
    .zero(acc && !in_range && !we),
    .be(clearing ? '1 : be),
    .addr(clearing ? cnt : addr),
    .wdata(clearing ? '0 : wdata),
    .rdata(rdata)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      cnt    <= '0;
      ready  <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= acc && !we;
      err    <= acc && !in_range;
      if (clearing) begin
        cnt   <= cnt == ADDRWIDTH'(SIZE-1) ? '0 : cnt + 1'b1;
        state <= cnt == ADDRWIDTH'(SIZE-1) ? READY : CLEAR;
        ready <= cnt == ADDRWIDTH'(SIZE-1);
      end else if (clr_start) begin
        state <= CLEAR;
        cnt   <= '0;
        ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sp_ram_be_clr.sv
// tb_sp_ram_be_clr: random and directed checks of three RDW-mode instances against a word-level model
module tb_sp_ram_be_clr;
  localparam int SIZE = 12;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        cs = 0, we = 0, clr_start = 0;
  logic [3:0]  be = 0, addr = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rd [3];
  logic        rv [3], rdy [3], er [3];
  int          checks = 0, errors = 0;
  int          clr_left;
  logic [31:0] mm [SIZE];
  logic [31:0] mrd [3];
  logic        mrv, mer;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sp_ram_be_clr #(.ADDRWIDTH(4), .DATAWIDTH(32), .SIZE(SIZE), .RDW_MODE(g)) u_dut (
      .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .be(be), .addr(addr), .wdata(wdata),
      .clr_start(clr_start), .rdata(rd[g]), .rvalid(rv[g]), .ready(rdy[g]), .err(er[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    clr_left = SIZE;
    mrv = 0;
    mer = 0;
    for (int m = 0; m < 3; m++) mrd[m] = 0;
  endtask

  // word-level behaviour: a clear is SIZE busy cycles zeroing words in order
  task automatic model_step();
    logic [31:0] old, nw;
    mrv = 0;
    mer = 0;
    if (clr_left > 0) begin
      mm[SIZE-clr_left] = 0;
      clr_left--;
    end else if (clr_start) clr_left = SIZE;
    else if (cs) begin
      if (int'(addr) >= SIZE) begin
        mer = 1;
        if (!we) begin
          mrv = 1;
          for (int m = 0; m < 3; m++) mrd[m] = 0;
        end
      end else if (!we) begin
        mrv = 1;
        for (int m = 0; m < 3; m++) mrd[m] = mm[addr];
      end else begin
        old = mm[addr];
        nw = old;
        for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
        mm[addr] = nw;
        mrd[1] = old;
        mrd[2] = nw;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("ready%0d", m), 32'(rdy[m]), 32'(clr_left == 0));
      chk($sformatf("rvalid%0d", m), 32'(rv[m]), 32'(mrv));
      chk($sformatf("err%0d", m), 32'(er[m]), 32'(mer));
      chk($sformatf("rdata%0d", m), rd[m], mrd[m]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic w, input logic [3:0] b, input logic [3:0] a,
                       input logic [31:0] d, input logic cl);
    cs = c;
    we = w;
    be = b;
    addr = a;
    wdata = d;
    clr_start = cl;
    cycle();
  endtask

  task automatic async_reset();
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    #1;
    rst_n = 1;
  endtask

  task automatic idle_until_ready();
    while (clr_left > 0) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < SIZE; a++) begin
      drive(1, 0, 0, 4'(a), 0, 0);
      chk(tag, rd[0], 0);
    end
  endtask

  initial begin
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;
    idle_until_ready();
    read_all_zero("clear_zero");
    drive(1, 1, 4'b0001, 3, 32'hA5, 0);
    drive(1, 0, 0, 3, 0, 0);
    chk("rd_a5", rd[0], 32'hA5);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 4'hF, 7, 32'h11223344, 0);
    drive(1, 1, 4'b0101, 7, 32'hAABBCCDD, 0);
    drive(1, 0, 0, 7, 0, 0);
    chk("be_merge", rd[0], 32'h11BB33DD);
    drive(1, 1, 4'hF, 5, 32'h10, 0);
    drive(1, 0, 0, 3, 0, 0);
    drive(1, 1, 4'hF, 5, 32'h20, 0);
    chk("rdw_nochange", rd[0], 32'hA5);
    chk("rdw_readfirst", rd[1], 32'h10);
    chk("rdw_writefirst", rd[2], 32'h20);
    drive(1, 0, 0, 13, 0, 0);
    chk("oor_rd_err", 32'(er[0]), 1);
    drive(1, 1, 4'hF, 13, 32'hFFFFFFFF, 0);
    drive(1, 1, 4'hF, 12, 32'h55, 0);
    drive(1, 0, 0, 15, 0, 0);
    drive(1, 1, 4'b0000, 3, 32'hFFFFFFFF, 0);
    drive(1, 0, 0, 3, 0, 0);
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 4'($urandom),
            $urandom, $urandom_range(0, 59) == 0);
      if ($urandom_range(0, 149) == 0) async_reset();
    end
    idle_until_ready();
    drive(1, 1, 4'hF, 2, 32'hDEADBEEF, 1);
    repeat (5) drive(1, 0, 0, 2, 0, 0);
    async_reset();
    idle_until_ready();
    read_all_zero("clr_rst_zero");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sp_ram_be_clr.md
SP_RAM_BE_CLR -- requirements
Module: sp_ram_be_clr

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 4, address width.
REQ-002 SHALL have parameter DATAWIDTH, default 8, data width; must be a multiple of 8.
REQ-003 SHALL have parameter SIZE, default 16, word count; 1 <= SIZE <= 2**ADDRWIDTH.
REQ-004 SHALL have parameter RDW_MODE, default 0, read-during-write mode: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port cs, input, 1, request strobe.
REQ-008 SHALL have port we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port be, input, DATAWIDTH/8, byte write enables; bit i covers bits 8i+7:8i.
REQ-010 SHALL have port addr, input, ADDRWIDTH, word address.
REQ-011 SHALL have port wdata, input, DATAWIDTH, write data.
REQ-012 SHALL have port rdata, output, DATAWIDTH, registered read data.
REQ-013 SHALL have port rvalid, output, 1, one-cycle pulse qualifying read data.
REQ-014 SHALL have port ready, output, 1, registered; requests accepted only when high.
REQ-015 SHALL have port clr_start, input, 1, pulse that requests a full-array zero clear.
REQ-016 SHALL have port err, output, 1, one-cycle pulse on an out-of-range access.

Function
REQ-017 SHALL implement states CLEAR and READY; ready SHALL be 1 exactly in READY.
REQ-018 CLEAR SHALL write zero to address k in the k-th cycle, k = 0..SIZE-1, then enter READY on the next edge; the clear lasts SIZE cycles.
REQ-019 In READY, clr_start=1 SHALL enter CLEAR with the counter at 0; any cs in that same cycle is dropped (no write, no rvalid, no err).
REQ-020 cs while ready=0 SHALL be ignored; clr_start during CLEAR SHALL be ignored.
REQ-021 Accepted read: rdata SHALL equal mem[addr] and rvalid SHALL be 1 in the following cycle (latency 1); fully pipelined, one request per cycle.
REQ-022 Accepted write SHALL update only the bytes whose be bit is 1; be=0 is a legal no-op write.
REQ-023 On an accepted write, rdata in the next cycle SHALL be: unchanged (mode 0), the prior word (mode 1), or the merged new word (mode 2); rvalid SHALL stay 0.
REQ-024 rdata SHALL hold its value when no read or write updates it.
REQ-025 addr >= SIZE: a write SHALL be discarded; a read SHALL return 0 with rvalid=1; err SHALL pulse 1 in the following cycle in both cases.
REQ-026 Back-to-back write then read of the same address SHALL return the written data.

Reset
REQ-027 rst_n=0 SHALL immediately force rdata=0, rvalid=0, err=0, ready=0, state CLEAR, counter 0.
REQ-028 After rst_n rises, the clear of REQ-018 SHALL run; reset asserted mid-clear or mid-access SHALL restart it from address 0.
REQ-029 Array contents are not reset directly; they are zero only through the clear.

Structure
REQ-030 Package sp_ram_pkg SHALL hold the RDW_MODE constants (RDW_NO_CHANGE, RDW_READ_FIRST, RDW_WRITE_FIRST) and the state enumeration.
REQ-031 Storage SHALL be a sub-module sp_ram_array (byte-enable write, registered read, RDW mode); the clear FSM, range check and handshake sit in the top.

Verification
REQ-032 Reset release, SIZE=16 -> ready=0 for 16 cycles, then 1; reading addresses 0..15 returns 0.
REQ-033 Write addr 3 = 0xA5 (be=1), then read 3 -> next cycle rdata=0xA5, rvalid=1 for one cycle.
REQ-034 DATAWIDTH=32: write 0x11223344, then write be=0b0101 data 0xAABBCCDD, then read -> 0x11BB33DD.
REQ-035 Modes 0, 1 and 2 with mem[5]=0x10: write 0x20 to 5 -> rdata is prior value / 0x10 / 0x20; rvalid=0.
REQ-036 SIZE=12: read addr 13 -> rdata=0, rvalid=1, err=1; write addr 13 -> err=1 and the array is unchanged.
REQ-037 clr_start together with a write, then rst_n pulsed mid-clear -> write dropped, ready low for 16 cycles after release, and all words read 0.
